// File: rtl/alarma_pkg.sv
// Shared types and default timing/source constants for the alarm speaker arbiter.
package alarma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned MIN_PLAY = 100_000_000;
  localparam int unsigned MAX_PLAY = 1_500_000_000;
  localparam int unsigned GAP      = 25_000_000;

  localparam int unsigned SRC_BOMBA       = 0;
  localparam int unsigned SRC_TANQUE_BAJO = 1;
  localparam int unsigned SRC_TANQUE_ALTO = 2;

endpackage

// File: rtl/alarma_arbitro_prio_enc.sv
// Lowest-index-first priority encoder returning {valid, index}.
module prio_enc #(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [W-1:0]  vec_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alarma_arbitro.sv
// Fixed-priority speaker arbiter with minimum/maximum play time, inter-grant gap
// and per-source timeout masking.
module alarma_arbitro #(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned MIN_PLAY = alarma_pkg::MIN_PLAY,
  parameter int unsigned MAX_PLAY = alarma_pkg::MAX_PLAY,
  parameter int unsigned GAP      = alarma_pkg::GAP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           req,
  input  logic [N_SRC-1:0]           tone_in,
  input  logic                       mute,
  output logic [N_SRC-1:0]           grant,
  output logic                       spk,
  output logic                       busy,
  output logic [$clog2(N_SRC)-1:0]   active_id
);

  import alarma_pkg::*;

  localparam int unsigned IW = $clog2(N_SRC);

  state_t           state_q, state_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      gap_q, gap_d;
  logic [IW-1:0]    active_id_q, active_id_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             spk_q, spk_d;
  logic             expire;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] lower_mask;
  logic             win_valid, hi_valid;
  logic [IW-1:0]    win_idx, hi_idx;

  assign eligible = req & ~mask_q;

  always_comb begin
    lower_mask = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      lower_mask[i] = (i < int'(active_id_q));
    end
  end

  prio_enc #(.W(N_SRC), .IW(IW)) u_win (
    .vec_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  prio_enc #(.W(N_SRC), .IW(IW)) u_hi (
    .vec_i   (eligible & lower_mask),
    .valid_o (hi_valid),
    .idx_o   (hi_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      gap_q       <= '0;
      active_id_q <= '0;
      mask_q      <= '0;
      spk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
      active_id_q <= active_id_d;
      mask_q      <= mask_d;
      spk_q       <= spk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    active_id_d = active_id_q;
    expire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d     = ST_PLAY;
          active_id_d = win_idx;
          timer_d     = '0;
        end
      end
      ST_PLAY: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == MAX_PLAY - 1) begin
          state_d = ST_GAP;
          gap_d   = '0;
          expire  = 1'b1;
        end else if ((timer_q >= MIN_PLAY - 1) && (!req[active_id_q] || hi_valid)) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_q == GAP - 1) begin
          if (win_valid) begin
            state_d     = ST_PLAY;
            active_id_d = win_idx;
            timer_d     = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A low request clears its mask bit even on the cycle the timeout sets it.
  always_comb begin
    mask_d = mask_q;
    if (expire) mask_d[active_id_q] = 1'b1;
    mask_d = mask_d & req;
  end

  always_comb begin
    grant = '0;
    if (state_q == ST_PLAY) grant[active_id_q] = 1'b1;
    busy  = (state_q == ST_PLAY);
    spk_d = (state_q == ST_PLAY) && tone_in[active_id_q] && !mute;
  end

  assign spk       = spk_q;
  assign active_id = active_id_q;

endmodule
